// File: rtl/texture_filter_pipe.sv
// texture_filter_pipe: 3-stage bilinear / linear-S / nearest texel filter
// with a valid/ready handshake and sideband passthrough.
// Optional feature macro: TEXTURE_FILTER_ROUND_EN (round-to-nearest lerp;
// when undefined the lerp truncates).
module texture_filter_pipe #(
    parameter int CHANNELS      = 4,
    parameter int CHANNEL_WIDTH = 8,
    parameter int FRAC_WIDTH    = 8,
    parameter int USER_WIDTH    = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] s_texel00,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] s_texel01,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] s_texel10,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] s_texel11,
    input  logic [FRAC_WIDTH-1:0]             s_frac_s,
    input  logic [FRAC_WIDTH-1:0]             s_frac_t,
    input  logic [1:0]                        s_mode,
    input  logic [USER_WIDTH-1:0]             s_user,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [CHANNELS*CHANNEL_WIDTH-1:0] m_texel,
    output logic [USER_WIDTH-1:0]             m_user
);

    localparam int LW = CHANNEL_WIDTH + FRAC_WIDTH + 1;

`ifdef TEXTURE_FILTER_ROUND_EN
    localparam logic [LW-1:0] RND = LW'(1) << (FRAC_WIDTH - 1);
`else
    localparam logic [LW-1:0] RND = '0;
`endif

    localparam logic [1:0] MODE_NEAREST = 2'b00;
    localparam logic [1:0] MODE_LIN_S   = 2'b10;

    typedef logic [CHANNELS-1:0][CHANNEL_WIDTH-1:0] texel_t;

    // L(a,b,f) = (a*(M-f) + b*f + R) >> F; the sum stays below 2^(CW+F),
    // so the result never exceeds max(a,b) and f=0 returns a exactly.
    function automatic logic [CHANNEL_WIDTH-1:0] lerp(
        input logic [CHANNEL_WIDTH-1:0] a,
        input logic [CHANNEL_WIDTH-1:0] b,
        input logic [FRAC_WIDTH-1:0]    f
    );
        logic [LW-1:0] wf;
        logic [LW-1:0] wmf;
        logic [LW-1:0] acc;
        wf  = LW'(f);
        wmf = (LW'(1) << FRAC_WIDTH) - wf;
        acc = LW'(a) * wmf + LW'(b) * wf + RND;
        return acc[FRAC_WIDTH +: CHANNEL_WIDTH];
    endfunction

    texel_t t00_w, t01_w, t10_w, t11_w;
    assign t00_w = s_texel00;
    assign t01_w = s_texel01;
    assign t10_w = s_texel10;
    assign t11_w = s_texel11;

    // Stage 1 state: horizontal lerps plus everything stage 2 still needs
    texel_t                  row0_q, row1_q, row0_d, row1_d, t00_q;
    logic [FRAC_WIDTH-1:0]   frac_t_q;
    logic [1:0]              mode_q;
    logic [USER_WIDTH-1:0]   user1_q;
    // Stage 2 state: mode-selected result
    texel_t                  bil_d, res2_d, res2_q;
    logic [USER_WIDTH-1:0]   user2_q;
    // Stage 3 state: output register
    texel_t                  out_q;
    logic [USER_WIDTH-1:0]   user3_q;
    // One valid bit per stage; index 3 is the output stage
    logic [3:1]              vld_q, vld_d;

    logic ce;

    // Whole pipe advances as one unit whenever the output slot is free
    assign ce      = !vld_q[3] | m_ready;
    assign s_ready = ce & !areset;
    assign vld_d   = {vld_q[2], vld_q[1], s_valid};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign row0_d[c] = lerp(t00_w[c], t01_w[c], s_frac_s);
        assign row1_d[c] = lerp(t10_w[c], t11_w[c], s_frac_s);
        assign bil_d[c]  = lerp(row0_q[c], row1_q[c], frac_t_q);
    end

    // Stage-2 mode select; mode 11 falls through to bilinear
    always_comb begin
        res2_d = bil_d;
        case (mode_q)
            MODE_NEAREST: res2_d = t00_q;
            MODE_LIN_S:   res2_d = row0_q;
            default:      res2_d = bil_d;
        endcase
    end

    // Pipeline registers: all stages load together on ce, hold otherwise
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_q    <= '0;
            row0_q   <= '0;
            row1_q   <= '0;
            t00_q    <= '0;
            frac_t_q <= '0;
            mode_q   <= '0;
            user1_q  <= '0;
            res2_q   <= '0;
            user2_q  <= '0;
            out_q    <= '0;
            user3_q  <= '0;
        end else if (ce) begin
            vld_q    <= vld_d;
            row0_q   <= row0_d;
            row1_q   <= row1_d;
            t00_q    <= t00_w;
            frac_t_q <= s_frac_t;
            mode_q   <= s_mode;
            user1_q  <= s_user;
            res2_q   <= res2_d;
            user2_q  <= user1_q;
            out_q    <= res2_q;
            user3_q  <= user2_q;
        end
    end

    assign m_valid = vld_q[3];
    assign m_texel = out_q;
    assign m_user  = user3_q;

endmodule

// File: tb/tb_texture_filter_pipe.sv
// Directed bench for texture_filter_pipe (default parameters).
module tb_texture_filter_pipe;

    logic        aclk, areset;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_texel00, s_texel01, s_texel10, s_texel11, m_texel;
    logic [7:0]  s_frac_s, s_frac_t;
    logic [1:0]  s_mode;
    logic [15:0] s_user, m_user;

    int checks = 0;
    int errors = 0;

`ifdef TEXTURE_FILTER_ROUND_EN
    localparam logic [31:0] EXP_BIL  = 32'h40404040;
    localparam logic [31:0] EXP_LINS = 32'h40404040;
`else
    localparam logic [31:0] EXP_BIL  = 32'h3F3F3F3F;
    localparam logic [31:0] EXP_LINS = 32'h3F3F3F3F;
`endif
    // 255*255/256 = 254.004, so both rounding modes give 0xFE
    localparam logic [31:0] EXP_EDGE = 32'hFEFEFEFE;

    texture_filter_pipe dut (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_texel00(s_texel00), .s_texel01(s_texel01),
        .s_texel10(s_texel10), .s_texel11(s_texel11),
        .s_frac_s(s_frac_s), .s_frac_t(s_frac_t),
        .s_mode(s_mode), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_texel(m_texel), .m_user(m_user)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Drives one beat into an idle pipe with m_ready=1 and returns the
    // first output seen plus the number of cycles it took (0 = timeout).
    task automatic run_beat(input logic [31:0] t00, t01, t10, t11,
                            input logic [7:0] fs, ft, input logic [1:0] md,
                            input logic [15:0] usr,
                            output logic [31:0] otex, output logic [15:0] ousr,
                            output int lat);
        @(posedge aclk); #1;
        s_valid = 1'b1; m_ready = 1'b1;
        s_texel00 = t00; s_texel01 = t01; s_texel10 = t10; s_texel11 = t11;
        s_frac_s = fs; s_frac_t = ft; s_mode = md; s_user = usr;
        @(posedge aclk); #1;
        s_valid = 1'b0;
        lat = 0;
        otex = '0; ousr = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge aclk);
            if (m_valid) begin
                lat = i; otex = m_texel; ousr = m_user;
                break;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        s_texel00 = '0; s_texel01 = '0; s_texel10 = '0; s_texel11 = '0;
        s_frac_s = '0; s_frac_t = '0; s_mode = '0; s_user = '0;
        #3;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_texel !== 32'h0) begin errors++; $display("FAIL reset_m_texel got %h want 0", m_texel); end
        checks++; if (m_user !== 16'h0) begin errors++; $display("FAIL reset_m_user got %h want 0", m_user); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        @(posedge aclk); @(posedge aclk);
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_bilinear();
        logic [31:0] tex; logic [15:0] usr; int lat;
        run_beat(32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                 8'h80, 8'h80, 2'b01, 16'hBEEF, tex, usr, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bil_latency got %0d want 3", lat); end
        checks++; if (tex !== EXP_BIL) begin errors++; $display("FAIL bil_texel got %h want %h", tex, EXP_BIL); end
        checks++; if (usr !== 16'hBEEF) begin errors++; $display("FAIL bil_user got %h want beef", usr); end
        // mode 11 behaves as bilinear
        run_beat(32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                 8'h80, 8'h80, 2'b11, 16'h0011, tex, usr, lat);
        checks++; if (tex !== EXP_BIL || lat !== 3) begin errors++; $display("FAIL mode11_texel got %h lat %0d want %h lat 3", tex, lat, EXP_BIL); end
    endtask

    task automatic test_nearest();
        logic [31:0] tex; logic [15:0] usr; int lat;
        run_beat(32'h12345678, $urandom, $urandom, $urandom,
                 8'($urandom), 8'($urandom), 2'b00, 16'h1234, tex, usr, lat);
        checks++; if (tex !== 32'h12345678 || lat !== 3) begin errors++; $display("FAIL nearest_texel got %h lat %0d want 12345678 lat 3", tex, lat); end
        checks++; if (usr !== 16'h1234) begin errors++; $display("FAIL nearest_user got %h want 1234", usr); end
    endtask

    task automatic test_linear_s();
        logic [31:0] tex; logic [15:0] usr; int lat;
        run_beat(32'h00000000, 32'hFFFFFFFF, $urandom, $urandom,
                 8'h40, 8'hFF, 2'b10, 16'h5A5A, tex, usr, lat);
        checks++; if (tex !== EXP_LINS) begin errors++; $display("FAIL lin_s_texel got %h want %h", tex, EXP_LINS); end
        run_beat(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                 8'h40, 8'h00, 2'b10, 16'h5A5B, tex, usr, lat);
        checks++; if (tex !== EXP_LINS) begin errors++; $display("FAIL lin_s_row1_indep got %h want %h", tex, EXP_LINS); end
    endtask

    task automatic test_edge_frac();
        logic [31:0] tex; logic [15:0] usr; int lat;
        run_beat(32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC,
                 8'h00, 8'h00, 2'b01, 16'h0001, tex, usr, lat);
        checks++; if (tex !== 32'hA1B2C3D4) begin errors++; $display("FAIL frac0_exact got %h want a1b2c3d4", tex); end
        run_beat(32'h00000000, 32'hFFFFFFFF, 32'h0, 32'h0,
                 8'hFF, 8'h00, 2'b10, 16'h0002, tex, usr, lat);
        checks++; if (tex !== EXP_EDGE) begin errors++; $display("FAIL fracFF_edge got %h want %h", tex, EXP_EDGE); end
        run_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 8'hFF, 8'hFF, 2'b01, 16'h0003, tex, usr, lat);
        checks++; if (tex !== 32'hFFFFFFFF) begin errors++; $display("FAIL no_overflow got %h want ffffffff", tex); end
    endtask

    task automatic test_back_pressure();
        int sent = 0, got = 0, cyc = 0;
        logic hold_prev = 1'b0;
        logic [31:0] ptex = '0, etex;
        logic [15:0] pusr = '0, eusr;
        @(posedge aclk); #1;
        s_mode = 2'b00; s_frac_s = 8'h33; s_frac_t = 8'h77;
        s_valid = 1'b1;
        s_texel00 = 32'h01010101; s_texel01 = ~32'h01010101;
        s_texel10 = 32'h0; s_texel11 = 32'h0; s_user = 16'hA000;
        m_ready = 1'($urandom_range(0, 1));
        while (got < 20 && cyc < 400) begin
            @(negedge aclk);
            cyc++;
            if (hold_prev) begin
                checks++;
                if (m_valid !== 1'b1 || m_texel !== ptex || m_user !== pusr) begin
                    errors++; $display("FAIL bp_stable got v%b %h/%h want v1 %h/%h", m_valid, m_texel, m_user, ptex, pusr);
                end
            end
            if (m_valid && !m_ready) begin
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_full got %b want 0", s_ready); end
            end
            if (m_valid && m_ready) begin
                etex = 32'h01010101 * 32'(got + 1);
                eusr = 16'hA000 + 16'(got);
                checks++;
                if (m_texel !== etex || m_user !== eusr) begin
                    errors++; $display("FAIL bp_order beat %0d got %h/%h want %h/%h", got, m_texel, m_user, etex, eusr);
                end
                got++;
            end
            hold_prev = m_valid && !m_ready;
            ptex = m_texel; pusr = m_user;
            if (s_valid && s_ready) sent++;
            @(posedge aclk); #1;
            s_valid = (sent < 20);
            s_texel00 = 32'h01010101 * 32'(sent + 1);
            s_texel01 = ~s_texel00;
            s_user = 16'hA000 + 16'(sent);
            m_ready = 1'($urandom_range(0, 1));
        end
        s_valid = 1'b0; m_ready = 1'b1;
        checks++; if (got !== 20) begin errors++; $display("FAIL bp_count got %0d want 20", got); end
        repeat (4) @(posedge aclk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] tex; logic [15:0] usr; int lat;
        @(posedge aclk); #1;
        s_valid = 1'b1; m_ready = 1'b0; s_mode = 2'b00;
        s_texel00 = 32'hDEADBEEF; s_user = 16'h0BAD;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_full got v%b r%b want v1 r0", m_valid, s_ready); end
        #2 areset = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_valid got %b want 0", m_valid); end
        checks++; if (m_texel !== 32'h0 || m_user !== 16'h0) begin errors++; $display("FAIL mid_rst_data got %h/%h want 0/0", m_texel, m_user); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got %b want 0", s_ready); end
        s_valid = 1'b0; m_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk); areset = 1'b0;
        run_beat(32'h0F1E2D3C, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 2'b00,
                 16'h7777, tex, usr, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mid_after_latency got %0d want 3", lat); end
        checks++; if (tex !== 32'h0F1E2D3C || usr !== 16'h7777) begin errors++; $display("FAIL mid_after_data got %h/%h want 0f1e2d3c/7777", tex, usr); end
    endtask

    initial begin
        test_reset();
        test_bilinear();
        test_nearest();
        test_linear_s();
        test_edge_frac();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
